// File: rtl/pcx_req_bridge.sv
//-----------------------------------------------------------------------------
// pcx_req_bridge
//
// Purpose:
//   Bridges the sparc core's PCX request interface into a circular FIFO for a
//   downstream consumer. The core presents a one-hot destination request in
//   stage PQ and the matching 124-bit payload one cycle later in stage PA.
//   The bridge registers the request (dest + atom) in a single request stage
//   and writes it into the FIFO tail together with the payload in the next
//   cycle, so back-to-back requests stream with no bubble.
//
//   The consumer sees the head entry combinationally. A head entry that opens
//   an atomic pair is held back until its partner is also queued, so a pair
//   can never be split by a stall between its two packets. Each pop returns a
//   registered per-destination grant to the core in the following cycle.
//
//   The bridge does no credit tracking: a write into a full FIFO with no
//   simultaneous pop is dropped and raises the sticky overflow flag. A request
//   with more than one destination bit set is discarded and raises the sticky
//   illegal-request flag. Both flags clear synchronously on err_clr, with a
//   new error in the same cycle taking priority over the clear.
//
// Parameters:
//   DEPTH               FIFO entry count, power of two in 2..16.
//
// Ports:
//   gclk                in   1    clock, all state on rising edge
//   reset               in   1    asynchronous active-high reset
//   spc_pcx_req_pq      in   5    one-hot destination request, 0 = idle
//   spc_pcx_atom_pq     in   1    first packet of an atomic pair
//   spc_pcx_data_pa     in   124  payload, one cycle after its request
//   pcx_spc_grant_px    out  5    registered grant, dest of last-cycle pop
//   pcx_fifo_valid      out  1    head entry available
//   pcx_fifo_ready      in   1    consumer accepts head entry
//   pcx_fifo_dest       out  5    head entry destination
//   pcx_fifo_atom       out  1    head entry atomic bit
//   pcx_fifo_data       out  124  head entry payload
//   pcx_fifo_count      out  5    occupied entries, 0..DEPTH
//   pcx_err_ovf         out  1    sticky overflow flag
//   pcx_err_req         out  1    sticky illegal-request flag
//   err_clr             in   1    synchronous clear of both sticky flags
//-----------------------------------------------------------------------------
module pcx_req_bridge #(
  parameter int DEPTH = 16
) (
  input  logic         gclk,
  input  logic         reset,
  input  logic [4:0]   spc_pcx_req_pq,
  input  logic         spc_pcx_atom_pq,
  input  logic [123:0] spc_pcx_data_pa,
  output logic [4:0]   pcx_spc_grant_px,
  output logic         pcx_fifo_valid,
  input  logic         pcx_fifo_ready,
  output logic [4:0]   pcx_fifo_dest,
  output logic         pcx_fifo_atom,
  output logic [123:0] pcx_fifo_data,
  output logic [4:0]   pcx_fifo_count,
  output logic         pcx_err_ovf,
  output logic         pcx_err_req,
  input  logic         err_clr
);

  localparam int             AW        = (DEPTH > 2) ? $clog2(DEPTH) : 1;
  localparam logic [4:0]     DEPTH_CNT = 5'(DEPTH);
  localparam logic [AW-1:0]  PTR_ONE   = AW'(1);

  // True when exactly one bit of the 5-bit request vector is set.
  function automatic logic is_onehot5(input logic [4:0] v);
    logic [4:0] v_m1;
    v_m1 = v - 5'd1;
    return (v != 5'd0) && ((v & v_m1) == 5'd0);
  endfunction

  // Request stage (PQ -> PA)
  logic        stage_vld;
  logic [4:0]  stage_dest;
  logic        stage_atom;

  // FIFO storage: split into per-field arrays, payload has no reset
  logic [4:0]   mem_dest [DEPTH];
  logic         mem_atom [DEPTH];
  logic [123:0] mem_data [DEPTH];

  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [4:0]    count;

  logic        req_legal;
  logic        req_illegal;
  logic        full;
  logic        head_atom;
  logic        head_valid;
  logic        pop;
  logic        wr_en;
  logic        ovf_event;
  logic        grant_q;
  logic [4:0]  grant;
  logic        err_ovf;
  logic        err_req;

  // Classify the incoming PQ request as legal one-hot or illegal multi-hot.
  always_comb begin
    req_legal   = 1'b0;
    req_illegal = 1'b0;
    if (is_onehot5(spc_pcx_req_pq)) begin
      req_legal = 1'b1;
    end else if (spc_pcx_req_pq != 5'd0) begin
      req_illegal = 1'b1;
    end else begin
      req_legal   = 1'b0;
      req_illegal = 1'b0;
    end
  end

  // Register a legal request's dest and atom bit for the PA-stage write.
  always_ff @(posedge gclk or posedge reset) begin
    if (reset) begin
      stage_vld  <= 1'b0;
      stage_dest <= 5'd0;
      stage_atom <= 1'b0;
    end else begin
      stage_vld <= req_legal;
      if (req_legal) begin
        stage_dest <= spc_pcx_req_pq;
        stage_atom <= spc_pcx_atom_pq;
      end
    end
  end

  // Head qualification, pop and write-acceptance decisions.
  always_comb begin
    full      = (count == DEPTH_CNT);
    head_atom = mem_atom[rd_ptr];
    // An atomic head is only released once its partner is also queued.
    if (count == 5'd0) begin
      head_valid = 1'b0;
    end else if (head_atom) begin
      head_valid = (count >= 5'd2);
    end else begin
      head_valid = 1'b1;
    end
    pop = head_valid && pcx_fifo_ready;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    wr_en     = stage_vld && (!full || pop);
    ovf_event = stage_vld && full && !pop;
  end

  // Write the staged request plus PA payload into the FIFO tail.
  always_ff @(posedge gclk) begin
    if (wr_en) begin
      mem_dest[wr_ptr] <= stage_dest;
      mem_atom[wr_ptr] <= stage_atom;
      mem_data[wr_ptr] <= spc_pcx_data_pa;
    end
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
  always_ff @(posedge gclk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= 5'd0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({wr_en, pop})
        2'b10:   count <= count + 5'd1;
        2'b01:   count <= count - 5'd1;
        default: count <= count;
      endcase
    end
  end

  // Grant returns the popped entry's destination one cycle after the pop.
  always_ff @(posedge gclk or posedge reset) begin
    if (reset) begin
      grant   <= 5'd0;
      grant_q <= 1'b0;
    end else begin
      grant_q <= pop;
      if (pop) begin
        grant <= mem_dest[rd_ptr];
      end else begin
        grant <= 5'd0;
      end
    end
  end

  // Sticky error flags; a new error wins over a same-cycle clear.
  always_ff @(posedge gclk or posedge reset) begin
    if (reset) begin
      err_ovf <= 1'b0;
      err_req <= 1'b0;
    end else begin
      if (ovf_event) begin
        err_ovf <= 1'b1;
      end else if (err_clr) begin
        err_ovf <= 1'b0;
      end
      if (req_illegal) begin
        err_req <= 1'b1;
      end else if (err_clr) begin
        err_req <= 1'b0;
      end
    end
  end

  assign pcx_spc_grant_px = grant_q ? grant : 5'd0;
  assign pcx_fifo_valid   = head_valid;
  assign pcx_fifo_dest    = mem_dest[rd_ptr];
  assign pcx_fifo_atom    = head_atom;
  assign pcx_fifo_data    = mem_data[rd_ptr];
  assign pcx_fifo_count   = count;
  assign pcx_err_ovf      = err_ovf;
  assign pcx_err_req      = err_req;

endmodule

// File: tb/tb_pcx_req_bridge.sv
//-----------------------------------------------------------------------------
// tb_pcx_req_bridge
//
// Self-checking bench for pcx_req_bridge (DEPTH = 16). A table of per-cycle
// input/expected-output records covers single packet, atomic pair and the
// illegal-request / sticky-flag behaviour; hand-written sequences cover fill
// with overflow, push/pop at full with pointer wrap, and reset mid-stream.
// Inputs are driven 1 time unit after the rising edge, outputs are sampled
// on the falling edge.
//-----------------------------------------------------------------------------
module tb_pcx_req_bridge;

  logic         gclk = 1'b0;
  logic         reset = 1'b1;
  logic [4:0]   req = 5'd0;
  logic         atom = 1'b0;
  logic [123:0] data = 124'd0;
  logic         ready = 1'b0;
  logic         err_clr = 1'b0;

  logic [4:0]   grant;
  logic         valid;
  logic [4:0]   h_dest;
  logic         h_atom;
  logic [123:0] h_data;
  logic [4:0]   count;
  logic         err_ovf;
  logic         err_req;

  int nchk = 0;
  int nfail = 0;

  pcx_req_bridge #(.DEPTH(16)) dut (
    .gclk             (gclk),
    .reset            (reset),
    .spc_pcx_req_pq   (req),
    .spc_pcx_atom_pq  (atom),
    .spc_pcx_data_pa  (data),
    .pcx_spc_grant_px (grant),
    .pcx_fifo_valid   (valid),
    .pcx_fifo_ready   (ready),
    .pcx_fifo_dest    (h_dest),
    .pcx_fifo_atom    (h_atom),
    .pcx_fifo_data    (h_data),
    .pcx_fifo_count   (count),
    .pcx_err_ovf      (err_ovf),
    .pcx_err_req      (err_req),
    .err_clr          (err_clr)
  );

  always #5 gclk = ~gclk;

  typedef struct {
    logic         rst;
    logic [4:0]   req;
    logic         atom;
    logic [123:0] data;
    logic         rdy;
    logic         clr;
    logic         e_valid;
    logic [4:0]   e_dest;
    logic         e_atom;
    logic [123:0] e_data;
    logic [4:0]   e_count;
    logic [4:0]   e_grant;
    logic         e_ovf;
    logic         e_ereq;
  } vec_t;

  localparam int NV = 21;
  vec_t vecs [NV];

  function automatic vec_t mk(
    input logic rst, input logic [4:0] rq, input logic at, input logic [123:0] d,
    input logic rdy, input logic clr,
    input logic ev, input logic [4:0] ed, input logic ea, input logic [123:0] edata,
    input logic [4:0] ec, input logic [4:0] eg, input logic eo, input logic er);
    vec_t v;
    v.rst = rst; v.req = rq; v.atom = at; v.data = d; v.rdy = rdy; v.clr = clr;
    v.e_valid = ev; v.e_dest = ed; v.e_atom = ea; v.e_data = edata;
    v.e_count = ec; v.e_grant = eg; v.e_ovf = eo; v.e_ereq = er;
    return v;
  endfunction

  function automatic logic [4:0] onehot(input int n);
    logic [4:0] one;
    one = 5'b00001;
    return one << (n % 5);
  endfunction

  task automatic chk(input string name, input logic [123:0] act, input logic [123:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic ev, input logic [4:0] ed,
                           input logic ea, input logic [123:0] edata, input logic [4:0] ec,
                           input logic [4:0] eg, input logic eo, input logic er);
    chk({tag, " valid"}, {123'd0, valid}, {123'd0, ev});
    chk({tag, " count"}, {119'd0, count}, {119'd0, ec});
    chk({tag, " grant"}, {119'd0, grant}, {119'd0, eg});
    chk({tag, " err_ovf"}, {123'd0, err_ovf}, {123'd0, eo});
    chk({tag, " err_req"}, {123'd0, err_req}, {123'd0, er});
    if (ev) begin
      chk({tag, " dest"}, {119'd0, h_dest}, {119'd0, ed});
      chk({tag, " atom"}, {123'd0, h_atom}, {123'd0, ea});
      chk({tag, " data"}, h_data, edata);
    end
  endtask

  // Advance to just after the next rising edge and return inputs to idle.
  task automatic start_cycle();
    @(posedge gclk);
    #1;
    req = 5'd0;
    atom = 1'b0;
    data = 124'd0;
    err_clr = 1'b0;
  endtask

  initial begin
    //           rst req       at data       rdy clr  ev dest      ea edata      cnt grant     ovf ereq
    vecs[0]  = mk(1'b1, 5'b00000, 1'b0, 124'h0,   1'b1, 1'b0, 1'b0, 5'b00000, 1'b0, 124'h0,   5'd0, 5'b00000, 1'b0, 1'b0);
    vecs[1]  = mk(1'b0, 5'b00001, 1'b0, 124'h0,   1'b1, 1'b0, 1'b0, 5'b00000, 1'b0, 124'h0,   5'd0, 5'b00000, 1'b0, 1'b0);
    vecs[2]  = mk(1'b0, 5'b00000, 1'b0, 124'hABC, 1'b1, 1'b0, 1'b0, 5'b00000, 1'b0, 124'h0,   5'd0, 5'b00000, 1'b0, 1'b0);
    vecs[3]  = mk(1'b0, 5'b00000, 1'b0, 124'h0,   1'b1, 1'b0, 1'b1, 5'b00001, 1'b0, 124'hABC, 5'd1, 5'b00000, 1'b0, 1'b0);
    vecs[4]  = mk(1'b0, 5'b00000, 1'b0, 124'h0,   1'b1, 1'b0, 1'b0, 5'b00000, 1'b0, 124'h0,   5'd0, 5'b00001, 1'b0, 1'b0);
    vecs[5]  = mk(1'b0, 5'b00000, 1'b0, 124'h0,   1'b1, 1'b0, 1'b0, 5'b00000, 1'b0, 124'h0,   5'd0, 5'b00000, 1'b0, 1'b0);
    vecs[6]  = mk(1'b0, 5'b00100, 1'b1, 124'h0,   1'b1, 1'b0, 1'b0, 5'b00000, 1'b0, 124'h0,   5'd0, 5'b00000, 1'b0, 1'b0);
    vecs[7]  = mk(1'b0, 5'b00100, 1'b0, 124'h111, 1'b1, 1'b0, 1'b0, 5'b00000, 1'b0, 124'h0,   5'd0, 5'b00000, 1'b0, 1'b0);
    vecs[8]  = mk(1'b0, 5'b00000, 1'b0, 124'h222, 1'b1, 1'b0, 1'b0, 5'b00000, 1'b0, 124'h0,   5'd1, 5'b00000, 1'b0, 1'b0);
    vecs[9]  = mk(1'b0, 5'b00000, 1'b0, 124'h0,   1'b1, 1'b0, 1'b1, 5'b00100, 1'b1, 124'h111, 5'd2, 5'b00000, 1'b0, 1'b0);
    vecs[10] = mk(1'b0, 5'b00000, 1'b0, 124'h0,   1'b1, 1'b0, 1'b1, 5'b00100, 1'b0, 124'h222, 5'd1, 5'b00100, 1'b0, 1'b0);
    vecs[11] = mk(1'b0, 5'b00000, 1'b0, 124'h0,   1'b1, 1'b0, 1'b0, 5'b00000, 1'b0, 124'h0,   5'd0, 5'b00100, 1'b0, 1'b0);
    vecs[12] = mk(1'b0, 5'b00000, 1'b0, 124'h0,   1'b1, 1'b0, 1'b0, 5'b00000, 1'b0, 124'h0,   5'd0, 5'b00000, 1'b0, 1'b0);
    vecs[13] = mk(1'b0, 5'b00011, 1'b0, 124'h0,   1'b1, 1'b0, 1'b0, 5'b00000, 1'b0, 124'h0,   5'd0, 5'b00000, 1'b0, 1'b0);
    vecs[14] = mk(1'b0, 5'b00000, 1'b0, 124'h333, 1'b1, 1'b0, 1'b0, 5'b00000, 1'b0, 124'h0,   5'd0, 5'b00000, 1'b0, 1'b1);
    vecs[15] = mk(1'b0, 5'b00000, 1'b0, 124'h0,   1'b1, 1'b1, 1'b0, 5'b00000, 1'b0, 124'h0,   5'd0, 5'b00000, 1'b0, 1'b1);
    vecs[16] = mk(1'b0, 5'b00000, 1'b0, 124'h0,   1'b1, 1'b0, 1'b0, 5'b00000, 1'b0, 124'h0,   5'd0, 5'b00000, 1'b0, 1'b0);
    vecs[17] = mk(1'b0, 5'b01010, 1'b0, 124'h0,   1'b1, 1'b1, 1'b0, 5'b00000, 1'b0, 124'h0,   5'd0, 5'b00000, 1'b0, 1'b0);
    vecs[18] = mk(1'b0, 5'b00000, 1'b0, 124'h0,   1'b1, 1'b0, 1'b0, 5'b00000, 1'b0, 124'h0,   5'd0, 5'b00000, 1'b0, 1'b1);
    vecs[19] = mk(1'b0, 5'b00000, 1'b0, 124'h0,   1'b1, 1'b1, 1'b0, 5'b00000, 1'b0, 124'h0,   5'd0, 5'b00000, 1'b0, 1'b1);
    vecs[20] = mk(1'b0, 5'b00000, 1'b0, 124'h0,   1'b1, 1'b0, 1'b0, 5'b00000, 1'b0, 124'h0,   5'd0, 5'b00000, 1'b0, 1'b0);

    // Table-driven: single packet, atomic pair, illegal request, flag clear.
    for (int i = 0; i < NV; i++) begin
      start_cycle();
      reset   = vecs[i].rst;
      req     = vecs[i].req;
      atom    = vecs[i].atom;
      data    = vecs[i].data;
      ready   = vecs[i].rdy;
      err_clr = vecs[i].clr;
      @(negedge gclk);
      check_all($sformatf("vec%0d", i), vecs[i].e_valid, vecs[i].e_dest, vecs[i].e_atom,
                vecs[i].e_data, vecs[i].e_count, vecs[i].e_grant, vecs[i].e_ovf, vecs[i].e_ereq);
    end

    // Fill with 17 back-to-back requests and ready low: entry 17 overflows.
    for (int c = 0; c < 18; c++) begin
      start_cycle();
      ready = 1'b0;
      if (c < 17) req = onehot(c);
      if (c > 0) data = 124'(c);
      @(negedge gclk);
      if (c == 17) check_all("fill_full", 1'b1, onehot(0), 1'b0, 124'd1, 5'd16, 5'd0, 1'b0, 1'b0);
    end
    for (int k = 1; k <= 16; k++) begin
      start_cycle();
      ready = 1'b1;
      @(negedge gclk);
      check_all($sformatf("ovf_drain%0d", k), 1'b1, onehot(k - 1), 1'b0, 124'(k), 5'(17 - k),
                (k == 1) ? 5'd0 : onehot(k - 2), 1'b1, 1'b0);
    end
    start_cycle();
    @(negedge gclk);
    check_all("ovf_empty", 1'b0, 5'd0, 1'b0, 124'd0, 5'd0, onehot(15), 1'b1, 1'b0);
    start_cycle();
    err_clr = 1'b1;
    @(negedge gclk);
    check_all("ovf_clr_cycle", 1'b0, 5'd0, 1'b0, 124'd0, 5'd0, 5'd0, 1'b1, 1'b0);
    start_cycle();
    @(negedge gclk);
    check_all("ovf_cleared", 1'b0, 5'd0, 1'b0, 124'd0, 5'd0, 5'd0, 1'b0, 1'b0);

    // Push and pop together at full: entry 17 is accepted, pointers wrap.
    for (int c = 0; c < 18; c++) begin
      start_cycle();
      ready = (c == 17);
      if (c < 17) req = onehot(c);
      if (c > 0) data = 124'(100 + c);
      @(negedge gclk);
      if (c == 17) check_all("pp_full", 1'b1, onehot(0), 1'b0, 124'd101, 5'd16, 5'd0, 1'b0, 1'b0);
    end
    for (int k = 2; k <= 17; k++) begin
      start_cycle();
      ready = 1'b1;
      @(negedge gclk);
      check_all($sformatf("pp_drain%0d", k), 1'b1, onehot(k - 1), 1'b0, 124'(100 + k),
                5'(18 - k), onehot(k - 2), 1'b0, 1'b0);
    end
    start_cycle();
    @(negedge gclk);
    check_all("pp_empty", 1'b0, 5'd0, 1'b0, 124'd0, 5'd0, onehot(16), 1'b0, 1'b0);

    // Reset mid-stream with 3 queued, one staged and a grant in flight.
    for (int c = 0; c < 4; c++) begin
      start_cycle();
      ready = 1'b0;
      if (c < 3) req = onehot(c + 2);
      if (c > 0) data = 124'(200 + c);
    end
    start_cycle();
    req = 5'b10000;
    ready = 1'b1;
    @(negedge gclk);
    check_all("rst_pre", 1'b1, 5'b00100, 1'b0, 124'd201, 5'd3, 5'd0, 1'b0, 1'b0);
    start_cycle();
    reset = 1'b1;
    data = 124'hDEAD;
    @(negedge gclk);
    check_all("rst_active", 1'b0, 5'd0, 1'b0, 124'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    start_cycle();
    reset = 1'b0;
    req = 5'b00010;
    @(negedge gclk);
    check_all("rst_rel", 1'b0, 5'd0, 1'b0, 124'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    start_cycle();
    data = 124'hDEF;
    @(negedge gclk);
    check_all("rst_pa", 1'b0, 5'd0, 1'b0, 124'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    start_cycle();
    @(negedge gclk);
    check_all("rst_new_head", 1'b1, 5'b00010, 1'b0, 124'hDEF, 5'd1, 5'd0, 1'b0, 1'b0);
    start_cycle();
    @(negedge gclk);
    check_all("rst_new_grant", 1'b0, 5'd0, 1'b0, 124'd0, 5'd0, 5'b00010, 1'b0, 1'b0);
    start_cycle();
    @(negedge gclk);
    check_all("rst_idle", 1'b0, 5'd0, 1'b0, 124'd0, 5'd0, 5'd0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", nchk, nfail);
    $finish;
  end

endmodule

// File: doc/pcx_req_bridge.md
PCX_REQ_BRIDGE -- requirements
Module: pcx_req_bridge

Interface
REQ-001 Parameter DEPTH, default 16, sets the FIFO entry count; legal values are powers of two from 2 to 16.
REQ-002 gclk  input  1  sole clock; all state updates on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 spc_pcx_req_pq  input  5  one-hot PCX destination request from the sparc core; 0 means idle.
REQ-005 spc_pcx_atom_pq  input  1  marks the first packet of an atomic pair; qualified by spc_pcx_req_pq.
REQ-006 spc_pcx_data_pa  input  124  packet payload, valid one cycle after its request.
REQ-007 pcx_spc_grant_px  output  5  per-destination grant back to the core.
REQ-008 pcx_fifo_valid  output  1  head entry available to the downstream consumer.
REQ-009 pcx_fifo_ready  input  1  downstream accepts the head entry.
REQ-010 pcx_fifo_dest / pcx_fifo_atom / pcx_fifo_data  output  5/1/124  head entry fields.
REQ-011 pcx_fifo_count  output  5  occupied entries, 0..DEPTH.
REQ-012 pcx_err_ovf / pcx_err_req  output  1 each  sticky overflow and illegal-request flags.
REQ-013 err_clr  input  1  synchronous clear of both sticky flags.

Function
REQ-014 Stage PQ: a non-zero one-hot spc_pcx_req_pq SHALL be registered with spc_pcx_atom_pq into a single request stage in cycle t.
REQ-015 Stage PA: in cycle t+1, the registered dest and atom SHALL be written into the FIFO tail together with spc_pcx_data_pa.
REQ-016 Back-to-back requests, one per cycle, SHALL be accepted with no bubble.
REQ-017 A non-zero spc_pcx_req_pq with more than one bit set SHALL produce no FIFO write and SHALL set pcx_err_req.
REQ-018 The FIFO is a circular buffer; read and write pointers SHALL wrap modulo DEPTH.
REQ-019 A pop occurs when pcx_fifo_valid and pcx_fifo_ready are both 1.
REQ-020 When a write and a pop occur in the same cycle, count SHALL be unchanged and both SHALL complete.
REQ-021 A write while count==DEPTH with no pop in the same cycle SHALL be dropped, SHALL set pcx_err_ovf, and SHALL leave FIFO contents unchanged.
REQ-022 A write while count==DEPTH with a pop in the same cycle SHALL be accepted.
REQ-023 pcx_fifo_valid SHALL be 1 when count>=1 and the head atom bit is 0.
REQ-024 pcx_fifo_valid SHALL be 1 when the head atom bit is 1 and count>=2, so an atomic pair is never split by a stall between its packets.
REQ-025 Head fields SHALL be driven combinationally from the read-pointer entry.
REQ-026 Head field values are don't-care when pcx_fifo_valid is 0.
REQ-027 Grant: in the cycle after a pop, pcx_spc_grant_px SHALL equal the popped entry's dest; otherwise it SHALL be 0 (registered output).
REQ-028 Sticky flags SHALL hold until err_clr=1.
REQ-029 If err_clr and a new error occur in the same cycle, the flag SHALL be set.
REQ-030 The bridge issues no credit tracking; core-side credit limits are the core's responsibility, and pcx_err_ovf flags their violation.

Reset
REQ-031 While reset=1: pointers, count, request stage, pcx_spc_grant_px, pcx_err_ovf and pcx_err_req SHALL be 0.
REQ-032 While reset=1, pcx_fifo_valid SHALL be 0.
REQ-033 Reset asserted mid-operation SHALL discard all queued entries and any packet in the request stage.
REQ-034 After reset, no grant SHALL be issued for packets discarded by that reset.
REQ-035 The first request is accepted in the first cycle after reset deasserts.
REQ-036 FIFO payload storage needs no reset.

Verification
REQ-037 Single packet: req=5'b00001 at t, data=124'hABC at t+1, ready=1 -> valid=1 at t+2 with dest=1, data=ABC; grant=5'b00001 at t+3.
REQ-038 Atomic pair: req=5'b00100 with atom=1 at t, then req=5'b00100 at t+1 -> valid=0 at t+2; valid=1 with atom=1 at t+3; two pops; grant=5'b00100 in two consecutive cycles.
REQ-039 Fill and overflow: ready=0, 17 requests with DEPTH=16 -> count=16 and pcx_err_ovf=1; entries 1..16 drain in order; err_clr=1 then clears the flag.
REQ-040 Simultaneous push/pop at full, with ready=1 in the write cycle -> count stays 16 and pcx_err_ovf=0.
REQ-041 Illegal request: req=5'b00011 -> no write, count=0, pcx_err_req=1.
REQ-042 Reset mid-stream: 3 entries queued, reset pulsed -> count=0, valid=0, grant=0; the next request is processed normally.
